// File: rtl/rf_pkg.sv
// Shared register-file types and sizes for the write-port arbiter slice.
package rf_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned NUM_REGS   = 32;

    // One pending register-file write: destination and data.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] waddr;
        logic [XLEN-1:0]       wdata;
    } rf_wreq_t;

endpackage

// File: rtl/rf_wq_fifo.sv
// Synchronous FIFO of pending register-file writes with count-based full/empty flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module rf_wq_fifo
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     nrst,
    input  logic     push,
    input  rf_wreq_t wr,
    input  logic     pop,
    output rf_wreq_t head,
    output logic     full,
    output logic     empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    rf_wreq_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr_q];

    // Storage is not reset; the count alone decides validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wr;
        end
    end

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: primary WB writes win, secondary (long-latency)
// results queue in a FIFO and drain in idle slots. Also tracks pending writes and
// raises wb_stall when the queue starves or fills.
// Optional feature macro: RF_BYPASS_EN adds combinational forwarding of the
// registered write to two read ports.
module rf_wport_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  p_valid,
    input  logic [REG_ADDR_W-1:0] p_waddr,
    input  logic [XLEN-1:0]       p_wdata,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [REG_ADDR_W-1:0] s_waddr,
    input  logic [XLEN-1:0]       s_wdata,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  wb_stall,
    output logic                  rf_wen,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata
`ifdef RF_BYPASS_EN
    ,
    input  logic [REG_ADDR_W-1:0] byp_raddr1,
    input  logic [REG_ADDR_W-1:0] byp_raddr2,
    output logic                  byp_hit1,
    output logic                  byp_hit2,
    output logic [XLEN-1:0]       byp_data1,
    output logic [XLEN-1:0]       byp_data2
`endif
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    rf_wreq_t              s_req;
    rf_wreq_t              head;
    logic                  fifo_full, fifo_empty;
    logic                  push, pop;
    logic                  wen_d;
    logic [REG_ADDR_W-1:0] waddr_d;
    logic [XLEN-1:0]       wdata_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic                  stall_q, stall_d;

    assign s_req.waddr = s_waddr;
    assign s_req.wdata = s_wdata;
    assign s_ready     = !fifo_full;
    assign push        = s_valid && !fifo_full;
    // Secondary results only drain when the primary leaves the slot free.
    assign pop         = !p_valid && !fifo_empty;
    assign busy        = busy_q;
    assign wb_stall    = stall_q;

    rf_wq_fifo #(
        .DEPTH (DEPTH)
    ) u_wq_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (push),
        .wr    (s_req),
        .pop   (pop),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Select the write for this slot; x0 writes are consumed with the enable dropped.
    always_comb begin
        wen_d   = 1'b0;
        waddr_d = rf_waddr;
        wdata_d = rf_wdata;
        if (p_valid) begin
            wen_d   = (p_waddr != '0);
            waddr_d = p_waddr;
            wdata_d = p_wdata;
        end else if (pop) begin
            wen_d   = (head.waddr != '0);
            waddr_d = head.waddr;
            wdata_d = head.wdata;
        end
    end

    // Register the selected write onto the register-file port.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_wen   <= wen_d;
            rf_waddr <= waddr_d;
            rf_wdata <= wdata_d;
        end
    end

    // Pending-write scoreboard: a same-cycle issue to the popped register keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (pop) begin
            busy_d[head.waddr] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Starvation counter and stall request; stall follows the registered state by a cycle.
    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (p_valid && (starve_q != SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + 1'b1;
        end
        stall_d = (starve_q == SW'(STARVE_LIMIT)) || fifo_full;
    end

    // Scoreboard, starvation and stall registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            busy_q   <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

`ifdef RF_BYPASS_EN
    // Forward the write the register file has not captured yet.
    always_comb begin
        byp_hit1  = rf_wen && (rf_waddr == byp_raddr1) && (byp_raddr1 != '0);
        byp_hit2  = rf_wen && (rf_waddr == byp_raddr2) && (byp_raddr2 != '0);
        byp_data1 = rf_wdata;
        byp_data2 = rf_wdata;
    end
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench for rf_wport_arbiter: vector table plus multi-cycle sequences,
// with a reference model feeding an expected-result queue.
module tb_rf_wport_arbiter;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LIMIT = 8;

    logic        clk = 1'b0;
    logic        nrst;
    logic        p_valid;
    logic [4:0]  p_waddr;
    logic [31:0] p_wdata;
    logic        s_valid;
    logic        s_ready;
    logic [4:0]  s_waddr;
    logic [31:0] s_wdata;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [31:0] busy;
    logic        wb_stall;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    rf_wport_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .p_valid   (p_valid),
        .p_waddr   (p_waddr),
        .p_wdata   (p_wdata),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_waddr   (s_waddr),
        .s_wdata   (s_wdata),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .busy      (busy),
        .wb_stall  (wb_stall),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    typedef struct {
        logic        wen;
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] busy;
        logic        stall;
    } exp_t;

    typedef struct {
        logic        pv;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        sv;
        logic [4:0]  sa;
        logic [31:0] sd;
        logic        iv;
        logic [4:0]  ir;
        logic        xwen;
        logic [4:0]  xa;
        logic [31:0] xd;
        logic [31:0] xbusy;
    } vec_t;

    int total = 0;
    int bad   = 0;

    ent_t        mq [$];
    exp_t        xq [$];
    logic [31:0] m_busy = '0;
    int          m_cnt  = 0;
    vec_t        tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                         input logic sv, input logic [4:0] sa, input logic [31:0] sd,
                         input logic iv, input logic [4:0] ir);
        p_valid = pv; p_waddr = pa; p_wdata = pd;
        s_valid = sv; s_waddr = sa; s_wdata = sd;
        iss_valid = iv; iss_rd = ir;
    endtask

    // Model one clock of the current inputs, then compare after the edge.
    task automatic step();
        exp_t e;
        ent_t h;
        ent_t n;
        logic popd;
        int   sz;
        sz = mq.size();
        chk("s_ready", 32'(s_ready), 32'(sz < DEPTH));
        e.wen = 1'b0; e.a = '0; e.d = '0; popd = 1'b0;
        if (p_valid) begin
            e.wen = (p_waddr != 0); e.a = p_waddr; e.d = p_wdata;
        end else if (sz > 0) begin
            h = mq.pop_front(); popd = 1'b1;
            e.wen = (h.a != 0); e.a = h.a; e.d = h.d;
            m_busy[h.a] = 1'b0;
        end
        if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
        m_busy[0] = 1'b0;
        e.stall = (m_cnt == LIMIT) || (sz == DEPTH);
        if (sz == 0 || popd) m_cnt = 0;
        else if (p_valid && m_cnt < LIMIT) m_cnt++;
        if (s_valid && sz < DEPTH) begin
            n.a = s_waddr; n.d = s_wdata;
            mq.push_back(n);
        end
        e.busy = m_busy;
        xq.push_back(e);
        @(posedge clk);
        #1;
        e = xq.pop_front();
        chk("rf_wen", 32'(rf_wen), 32'(e.wen));
        if (e.wen) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(e.a));
            chk("rf_wdata", rf_wdata, e.d);
        end
        chk("busy", busy, e.busy);
        chk("wb_stall", 32'(wb_stall), 32'(e.stall));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            pv pa  pd            sv sa  sd            iv ir   xwen xa  xd            xbusy
        tbl[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 1'b0, 5'd0, 32'h0,        32'h0000_0020};
        tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0000_0020};
        tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0};
        tbl[3]  = '{1'b1, 5'd3, 32'h11111111, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 5'd3, 32'h11111111, 32'h0};
        tbl[4]  = '{1'b1, 5'd0, 32'h22222222, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0};
        tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h33333333, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h77777777, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0,        32'h0000_0080};
        tbl[8]  = '{1'b1, 5'd9, 32'h99999999, 1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 1'b1, 5'd9, 32'h99999999, 32'h0000_0080};
        tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b1, 5'd7, 32'h77777777, 32'h0000_0080};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd2, 1'b0, 5'd0, 32'h0,        32'h0000_0084};

        // Power-on reset.
        nrst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        chk("rst_rf_wen", 32'(rf_wen), 32'h0);
        chk("rst_rf_waddr", 32'(rf_waddr), 32'h0);
        chk("rst_rf_wdata", rf_wdata, 32'h0);
        chk("rst_busy", busy, 32'h0);
        chk("rst_wb_stall", 32'(wb_stall), 32'h0);
        chk("rst_s_ready", 32'(s_ready), 32'h1);

        // Vector table: latency, x0 writes, scoreboard set/clear collision.
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].pv, tbl[i].pa, tbl[i].pd, tbl[i].sv, tbl[i].sa, tbl[i].sd,
                  tbl[i].iv, tbl[i].ir);
            step();
            chk($sformatf("tbl%0d_wen", i), 32'(rf_wen), 32'(tbl[i].xwen));
            if (tbl[i].xwen) begin
                chk($sformatf("tbl%0d_waddr", i), 32'(rf_waddr), 32'(tbl[i].xa));
                chk($sformatf("tbl%0d_wdata", i), rf_wdata, tbl[i].xd);
            end
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].xbusy);
        end

        // Starvation: one queued entry blocked by continuous primary writes.
        drive(1'b1, 5'd10, 32'h1000, 1'b1, 5'd4, 32'hA5A5A5A5, 1'b0, 5'd0);
        step();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 5'd10, 32'h1001 + 32'(i), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
            step();
        end
        chk("starve_not_yet", 32'(wb_stall), 32'h0);
        step();
        chk("starve_stall", 32'(wb_stall), 32'h1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        step();
        chk("starve_commit_wen", 32'(rf_wen), 32'h1);
        chk("starve_commit_data", rf_wdata, 32'hA5A5A5A5);
        chk("starve_stall_hold", 32'(wb_stall), 32'h1);
        step();
        chk("starve_stall_drop", 32'(wb_stall), 32'h0);

        // Fill: four pushes under primary traffic, fifth held off until a pop.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd20, 32'h2000 + 32'(i), 1'b1, 5'd11 + 5'(i), 32'hB000 + 32'(i),
                  1'b0, 5'd0);
            step();
        end
        chk("full_s_ready", 32'(s_ready), 32'h0);
        drive(1'b1, 5'd20, 32'h2004, 1'b1, 5'd15, 32'hB004, 1'b0, 5'd0);
        step();
        chk("full_stall", 32'(wb_stall), 32'h1);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd15, 32'hB004, 1'b0, 5'd0);
        step();
        chk("full_pop_first", 32'(rf_waddr), 32'd11);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        for (int i = 0; i < 4; i++) step();
        chk("full_fifth_last", rf_wdata, 32'hB004);
        chk("full_drained", 32'(mq.size()), 32'h0);

        // Reset mid-operation with two queued entries and primary active.
        drive(1'b1, 5'd20, 32'h3000, 1'b1, 5'd21, 32'hC001, 1'b0, 5'd0);
        step();
        drive(1'b1, 5'd20, 32'h3001, 1'b1, 5'd22, 32'hC002, 1'b0, 5'd0);
        step();
        drive(1'b1, 5'd20, 32'h3002, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        #2;
        nrst = 1'b0;
        #1;
        chk("mrst_rf_wen", 32'(rf_wen), 32'h0);
        chk("mrst_rf_waddr", 32'(rf_waddr), 32'h0);
        chk("mrst_rf_wdata", rf_wdata, 32'h0);
        chk("mrst_busy", busy, 32'h0);
        chk("mrst_wb_stall", 32'(wb_stall), 32'h0);
        chk("mrst_s_ready", 32'(s_ready), 32'h1);
        mq.delete();
        m_busy = '0;
        m_cnt  = 0;
        @(posedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        @(negedge clk);
        nrst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("mrst_no_commit%0d", i), 32'(rf_wen), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_wport_arbiter.md
Name: rf_wport_arbiter

Overview:
Shares the register file's single write port between the in-order pipeline writeback (primary) and long-latency units such as load returns and mul/div (secondary). Secondary results are buffered in a small FIFO and committed in idle primary slots. The block also keeps a 32-bit pending-write scoreboard for hazard detection and forces a pipeline stall when secondary results starve. It sits between the WB stage, the long-latency units, and the register file write port.

Parameters:
DEPTH, 4, secondary FIFO entries (power of 2, >=2)
STARVE_LIMIT, 8, consecutive cycles the FIFO head may be blocked before wb_stall is raised

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
p_valid  in  1  primary write request; no backpressure
p_waddr  in  5  primary destination
p_wdata  in  32  primary data
s_valid  in  1  secondary write request
s_ready  out  1  FIFO can accept (= !full)
s_waddr  in  5  secondary destination
s_wdata  in  32  secondary data
iss_valid  in  1  long-latency op issued this cycle
iss_rd  in  5  its destination
busy  out  32  pending-write scoreboard; bit 0 is always 0
wb_stall  out  1  pipeline must hold p_valid low next cycle
rf_wen  out  1  register file write enable (registered)
rf_waddr  out  5  registered
rf_wdata  out  32  registered

Behaviour:
- Reset: async on nrst low. rf_wen=0, rf_waddr=0, rf_wdata=0, busy=0, wb_stall=0, FIFO empty (s_ready=1), starvation counter=0. Reset mid-operation discards all FIFO contents and pending state.
- Secondary push: s_valid && s_ready at the edge. No push while full, including when a pop happens in the same cycle; s_ready is a pure function of the registered count.
- Port select each cycle: p_valid wins. Otherwise, a non-empty FIFO pops its head. Otherwise, idle.
- The selected write is registered onto rf_* at the edge: 1-cycle latency for primary. A secondary result takes at least 2 cycles from push to rf_wen, because it always passes through the FIFO.
- Writes to x0 from either source are consumed but produce rf_wen=0 on that cycle.
- Scoreboard:
  - iss_valid && iss_rd!=0 sets busy[iss_rd].
  - Popping a secondary entry clears busy[waddr].
  - If set and clear hit the same register in one cycle, the set wins.
- Contract: the pipeline does not issue a primary write or a new iss_rd to a register whose busy bit is set. The block does not check or order WAW.
- Starvation counter:
  - Increments while the FIFO is non-empty and p_valid=1. Resets on every pop or when the FIFO is empty. Saturates at STARVE_LIMIT.
  - wb_stall is registered. It asserts the cycle after the counter reaches STARVE_LIMIT, or the cycle after the FIFO becomes full.
  - wb_stall deasserts the cycle after a pop leaves the FIFO non-full with the counter at 0.
- If p_valid=1 while wb_stall=1 (protocol violation), primary still wins.

Optional Feature:
RF_BYPASS_EN. When defined, add inputs byp_raddr1 and byp_raddr2 (5 bits each) and outputs byp_hit1/byp_hit2 (1 bit) and byp_data1/byp_data2 (32 bits), all combinational.
- byp_hitN = rf_wen && rf_waddr==byp_raddrN && byp_raddrN!=0.
- byp_dataN = rf_wdata.
- This covers the cycle before the register file captures the write.
When not defined, these ports do not exist and there is no extra logic.

Decomposition:
- Shared package rf_pkg: REG_ADDR_W=5, XLEN=32, NUM_REGS=32, typedef rf_wreq_t {waddr, wdata}.
- One sub-module: rf_wq_fifo, a parameterised synchronous FIFO of rf_wreq_t with count-based full/empty flags.
- Arbitration, scoreboard and starvation logic stay in the top module.

Test Plan:
- Reset with p_valid=1 and FIFO holding 2 entries -> all outputs 0 and s_ready=1 immediately while nrst is low, and the entries are never written.
- s_valid, waddr=5, data=0xDEADBEEF pushed at cycle 0 with no primary -> rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF at cycle 2. Preceded by iss_rd=5: busy[5]=1, then 0 after the pop.
- Primary writes every cycle, 1 secondary entry pushed -> wb_stall rises after 8 blocked cycles. With p_valid then held 0, the entry commits and wb_stall falls the next cycle.
- 4 secondary pushes with primary busy -> s_ready=0 after the 4th push and wb_stall=1. A 5th s_valid is not accepted until a pop.
- p_waddr=0 and s_waddr=0 writes -> rf_wen stays 0; busy is unchanged.
- iss_valid with iss_rd=7 in the same cycle as popping an entry for reg 7 -> busy[7] remains 1.
